// File: rtl/led_pwm_blink_driver_if.sv
// led_pwm_blink_driver_if
// MMIO-side bus bundle for the LED controller: write strobe, chip-select,
// register address, write data and combinational readback.
// The CPU/bus side uses the master modport; the LED controller uses slave.
interface led_pwm_blink_driver_if #(
  parameter int LED_W = 16
) ();
  logic             ledwrite;
  logic             ledcs;
  logic [1:0]       ledaddr;
  logic [LED_W-1:0] ledinputdata;
  logic [LED_W-1:0] ledrdata;

  modport master (
    output ledwrite,
    output ledcs,
    output ledaddr,
    output ledinputdata,
    input  ledrdata
  );

  modport slave (
    input  ledwrite,
    input  ledcs,
    input  ledaddr,
    input  ledinputdata,
    output ledrdata
  );
endinterface

// File: rtl/led_pwm_blink_driver.sv
// led_pwm_blink_driver
// Memory-mapped LED output controller with a pattern register, global PWM
// brightness and an optional per-LED blink engine.
//   addr0 PATTERN, addr1 BLINK_MASK, addr2 DUTY, addr3 PERIOD
// Optional feature macro: LED_BLINK_EN. Define it to build the blink engine
// (BLINK_MASK / PERIOD registers, prescaler, tick counter, phase). Without it,
// addr1/addr3 writes are ignored and both read as zero.
// Reset state (PATTERN=0, DUTY=all-ones, no blink) makes an addr0 write act
// as a plain latched LED port at full brightness.
module led_pwm_blink_driver #(
  parameter int LED_W     = 16,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 1000,
  parameter int BLINK_RST = 249
) (
  input  logic                         ledclk,
  input  logic                         ledrst,
  led_pwm_blink_driver_if.slave        ledbus,
  output logic [LED_W-1:0]             ledout
);

  // Reject parameter combinations the datapath cannot represent.
  if (PRESCALE < 1 || LED_W < PWM_BITS || LED_W > 32 || BLINK_RST < 0) begin : g_cfg_check
    $error("led_pwm_blink_driver: invalid parameter combination");
  end

  logic                w_wr;
  logic [LED_W-1:0]    r_pattern;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_pwm_on;
  logic [LED_W-1:0]    w_blank;
  logic [LED_W-1:0]    w_next_led;
  logic [LED_W-1:0]    w_rdata;

  assign w_wr = ledbus.ledcs & ledbus.ledwrite;

  // PATTERN and DUTY registers, written only on a qualified bus write.
  always_ff @(posedge ledclk or posedge ledrst) begin
    if (ledrst) begin
      r_pattern <= {LED_W{1'b0}};
      r_duty    <= {PWM_BITS{1'b1}};
    end else if (w_wr && ledbus.ledaddr == 2'd0) begin
      r_pattern <= ledbus.ledinputdata;
    end else if (w_wr && ledbus.ledaddr == 2'd2) begin
      r_duty    <= ledbus.ledinputdata[PWM_BITS-1:0];
    end else begin
      r_pattern <= r_pattern;
      r_duty    <= r_duty;
    end
  end

  // Free-running PWM phase counter; natural wrap at 2**PWM_BITS.
  always_ff @(posedge ledclk or posedge ledrst) begin
    if (ledrst) begin
      r_pwm_cnt <= {PWM_BITS{1'b0}};
    end else begin
      r_pwm_cnt <= r_pwm_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end
  end

  // All-ones duty must be solidly on, so it bypasses the compare.
  assign w_pwm_on = (&r_duty) | (r_pwm_cnt < r_duty);

`ifdef LED_BLINK_EN
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [LED_W-1:0] r_mask;
  logic [LED_W-1:0] r_period;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [LED_W-1:0] r_tick_cnt;
  logic             r_phase;
  logic             w_tick;
  logic             w_period_wr;

  assign w_period_wr = w_wr && (ledbus.ledaddr == 2'd3);
  assign w_tick      = (r_pre_cnt == PRE_W'(PRESCALE - 1));

  // BLINK_MASK and PERIOD registers.
  always_ff @(posedge ledclk or posedge ledrst) begin
    if (ledrst) begin
      r_mask   <= {LED_W{1'b0}};
      r_period <= LED_W'(BLINK_RST);
    end else if (w_wr && ledbus.ledaddr == 2'd1) begin
      r_mask   <= ledbus.ledinputdata;
    end else if (w_period_wr) begin
      r_period <= ledbus.ledinputdata;
    end else begin
      r_mask   <= r_mask;
      r_period <= r_period;
    end
  end

  // Blink timebase; a PERIOD write restarts it lit so a shorter period can never be overrun.
  always_ff @(posedge ledclk or posedge ledrst) begin
    if (ledrst) begin
      r_pre_cnt  <= {PRE_W{1'b0}};
      r_tick_cnt <= {LED_W{1'b0}};
      r_phase    <= 1'b1;
    end else if (w_period_wr) begin
      r_pre_cnt  <= {PRE_W{1'b0}};
      r_tick_cnt <= {LED_W{1'b0}};
      r_phase    <= 1'b1;
    end else if (w_tick) begin
      r_pre_cnt <= {PRE_W{1'b0}};
      if (r_tick_cnt == r_period) begin
        r_tick_cnt <= {LED_W{1'b0}};
        r_phase    <= ~r_phase;
      end else begin
        r_tick_cnt <= r_tick_cnt + {{(LED_W-1){1'b0}}, 1'b1};
        r_phase    <= r_phase;
      end
    end else begin
      r_pre_cnt  <= r_pre_cnt + {{(PRE_W-1){1'b0}}, 1'b1};
      r_tick_cnt <= r_tick_cnt;
      r_phase    <= r_phase;
    end
  end

  assign w_blank = r_mask & {LED_W{~r_phase}};
`else
  assign w_blank = {LED_W{1'b0}};
`endif

  assign w_next_led = r_pattern & ~w_blank & {LED_W{w_pwm_on}};

  // Registered LED drive so pins never see decode glitches.
  always_ff @(posedge ledclk or posedge ledrst) begin
    if (ledrst) begin
      ledout <= {LED_W{1'b0}};
    end else begin
      ledout <= w_next_led;
    end
  end

  // Combinational readback of the addressed register; chip-select is not consulted.
  always_comb begin
    w_rdata = {LED_W{1'b0}};
    case (ledbus.ledaddr)
      2'd0: w_rdata = r_pattern;
`ifdef LED_BLINK_EN
      2'd1: w_rdata = r_mask;
      2'd3: w_rdata = r_period;
`endif
      2'd2: w_rdata[PWM_BITS-1:0] = r_duty;
      default: w_rdata = {LED_W{1'b0}};
    endcase
  end

  assign ledbus.ledrdata = w_rdata;

endmodule

// File: tb/tb_led_pwm_blink_driver.sv
// tb_led_pwm_blink_driver
// Directed self-checking bench for led_pwm_blink_driver (LED_W=16,
// PWM_BITS=8, PRESCALE=4, BLINK_RST=249). Blink checks are built when
// LED_BLINK_EN is defined, the disabled-feature checks otherwise.
module tb_led_pwm_blink_driver;
  localparam int LED_W     = 16;
  localparam int PWM_BITS  = 8;
  localparam int PRESCALE  = 4;
  localparam int BLINK_RST = 249;

  logic             ledclk = 1'b0;
  logic             ledrst;
  logic [LED_W-1:0] ledout;

  int total = 0;
  int bad   = 0;

  led_pwm_blink_driver_if #(.LED_W(LED_W)) bus ();

  led_pwm_blink_driver #(
    .LED_W(LED_W), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .BLINK_RST(BLINK_RST)
  ) dut (
    .ledclk (ledclk),
    .ledrst (ledrst),
    .ledbus (bus.slave),
    .ledout (ledout)
  );

  always #5 ledclk = ~ledclk;

  // Qualified write; returns 1ns after the capturing edge.
  task automatic wr(input logic [1:0] a, input logic [LED_W-1:0] d);
    @(negedge ledclk);
    bus.ledcs = 1'b1; bus.ledwrite = 1'b1; bus.ledaddr = a; bus.ledinputdata = d;
    @(posedge ledclk);
    #1;
    bus.ledcs = 1'b0; bus.ledwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [LED_W-1:0] d);
    bus.ledaddr = a;
    #1;
    d = bus.ledrdata;
  endtask

  task automatic test_reset;
    logic [LED_W-1:0] d;
    ledrst = 1'b1;
    bus.ledcs = 1'b0; bus.ledwrite = 1'b0; bus.ledaddr = 2'd0; bus.ledinputdata = '0;
    repeat (3) @(posedge ledclk);
    #1;
    total++; if (ledout !== 16'h0000) begin bad++; $display("FAIL reset_ledout got=%h exp=%h", ledout, 16'h0000); end
    rd(2'd0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_pattern got=%h exp=%h", d, 16'h0000); end
    rd(2'd2, d);
    total++; if (d !== 16'h00FF) begin bad++; $display("FAIL reset_duty got=%h exp=%h", d, 16'h00FF); end
    rd(2'd1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_mask got=%h exp=%h", d, 16'h0000); end
    rd(2'd3, d);
`ifdef LED_BLINK_EN
    total++; if (d !== 16'(BLINK_RST)) begin bad++; $display("FAIL reset_period got=%h exp=%h", d, 16'(BLINK_RST)); end
`else
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_period got=%h exp=%h", d, 16'h0000); end
`endif
    @(negedge ledclk);
    ledrst = 1'b0;
  endtask

  task automatic test_latch;
    wr(2'd0, 16'hA5C3);
    total++; if (ledout !== 16'h0000) begin bad++; $display("FAIL latch_write_edge got=%h exp=%h", ledout, 16'h0000); end
    for (int i = 0; i < 6; i++) begin
      @(posedge ledclk); #1;
      total++; if (ledout !== 16'hA5C3) begin bad++; $display("FAIL latch_hold[%0d] got=%h exp=%h", i, ledout, 16'hA5C3); end
    end
  endtask

  task automatic test_cs_qualify;
    logic [LED_W-1:0] d;
    @(negedge ledclk);
    bus.ledcs = 1'b0; bus.ledwrite = 1'b1; bus.ledaddr = 2'd0; bus.ledinputdata = 16'hFFFF;
    @(negedge ledclk);
    bus.ledcs = 1'b1; bus.ledwrite = 1'b0;
    @(negedge ledclk);
    bus.ledcs = 1'b0; bus.ledwrite = 1'b0;
    @(posedge ledclk); #1;
    total++; if (ledout !== 16'hA5C3) begin bad++; $display("FAIL nocs_ledout got=%h exp=%h", ledout, 16'hA5C3); end
    rd(2'd0, d);
    total++; if (d !== 16'hA5C3) begin bad++; $display("FAIL nocs_pattern got=%h exp=%h", d, 16'hA5C3); end
  endtask

  task automatic test_duty;
    logic [LED_W-1:0] d;
    int on_cnt;
    int other_cnt;
    logic [7:0] duties [3];
    int         expect_on [3];
    duties[0] = 8'd64;  expect_on[0] = 64;
    duties[1] = 8'd0;   expect_on[1] = 0;
    duties[2] = 8'd255; expect_on[2] = 256;
    wr(2'd0, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      wr(2'd2, {8'hA0, duties[k]});
      rd(2'd2, d);
      total++; if (d !== {8'h00, duties[k]}) begin bad++; $display("FAIL duty_readback[%0d] got=%h exp=%h", k, d, {8'h00, duties[k]}); end
      @(posedge ledclk); #1;
      on_cnt = 0; other_cnt = 0;
      for (int c = 0; c < 256; c++) begin
        @(posedge ledclk); #1;
        if (ledout === 16'hFFFF) on_cnt++;
        else if (ledout !== 16'h0000) other_cnt++;
      end
      total++; if (on_cnt !== expect_on[k]) begin bad++; $display("FAIL duty_on_cycles[%0d] got=%0d exp=%0d", k, on_cnt, expect_on[k]); end
      total++; if (other_cnt !== 0) begin bad++; $display("FAIL duty_partial[%0d] got=%0d exp=0", k, other_cnt); end
    end
  endtask

`ifdef LED_BLINK_EN
  task automatic test_blink;
    logic [LED_W-1:0] d;
    logic [LED_W-1:0] exp_v;
    wr(2'd2, 16'h00FF);
    wr(2'd0, 16'h00FF);
    wr(2'd1, 16'h000F);
    rd(2'd1, d);
    total++; if (d !== 16'h000F) begin bad++; $display("FAIL blink_mask_rd got=%h exp=%h", d, 16'h000F); end
    wr(2'd3, 16'd1);
    rd(2'd3, d);
    total++; if (d !== 16'd1) begin bad++; $display("FAIL blink_period_rd got=%h exp=%h", d, 16'd1); end
    for (int k = 1; k <= 40; k++) begin
      @(posedge ledclk); #1;
      exp_v = ((((k - 1) / 8) % 2) == 0) ? 16'h00FF : 16'h00F0;
      total++; if (ledout !== exp_v) begin bad++; $display("FAIL blink[%0d] got=%h exp=%h", k, ledout, exp_v); end
    end
  endtask
`endif

  task automatic test_reset_mid;
    logic [LED_W-1:0] d;
    int waited;
    wr(2'd0, 16'hFFFF);
    wr(2'd2, 16'h0010);
    waited = 0;
    while (ledout === 16'h0000 && waited < 300) begin
      @(posedge ledclk); #1;
      waited++;
    end
    total++; if (ledout !== 16'hFFFF) begin bad++; $display("FAIL midrst_lit_before got=%h exp=%h", ledout, 16'hFFFF); end
    #2;
    ledrst = 1'b1;
    #1;
    total++; if (ledout !== 16'h0000) begin bad++; $display("FAIL midrst_ledout got=%h exp=%h", ledout, 16'h0000); end
    rd(2'd2, d);
    total++; if (d !== 16'h00FF) begin bad++; $display("FAIL midrst_duty got=%h exp=%h", d, 16'h00FF); end
    rd(2'd0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL midrst_pattern got=%h exp=%h", d, 16'h0000); end
    rd(2'd3, d);
`ifdef LED_BLINK_EN
    total++; if (d !== 16'(BLINK_RST)) begin bad++; $display("FAIL midrst_period got=%h exp=%h", d, 16'(BLINK_RST)); end
`else
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL midrst_period got=%h exp=%h", d, 16'h0000); end
`endif
    @(negedge ledclk);
    ledrst = 1'b0;
  endtask

`ifndef LED_BLINK_EN
  task automatic test_no_blink;
    logic [LED_W-1:0] d;
    wr(2'd0, 16'h1234);
    wr(2'd1, 16'hFFFF);
    wr(2'd3, 16'd5);
    rd(2'd1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL noblink_mask_rd got=%h exp=%h", d, 16'h0000); end
    rd(2'd3, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL noblink_period_rd got=%h exp=%h", d, 16'h0000); end
    for (int k = 0; k < 20; k++) begin
      @(posedge ledclk); #1;
      total++; if (ledout !== 16'h1234) begin bad++; $display("FAIL noblink_ledout[%0d] got=%h exp=%h", k, ledout, 16'h1234); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latch();
    test_cs_qualify();
    test_duty();
`ifdef LED_BLINK_EN
    test_blink();
`endif
    test_reset_mid();
`ifndef LED_BLINK_EN
    test_no_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
